// File: rtl/mem_responder_if.sv
// Request/response bus between a memory master and mem_responder.
//
// Handshake: a request is taken on a rising edge where o_mem_ready=1 and
// exactly one of i_mem_ren/i_mem_wen is 1. A request that is not taken
// leaves no trace. Reads answer with a single-cycle o_mem_valid pulse and
// data on o_mem_rdata. Writes are never acknowledged.
interface mem_responder_if;
    logic        o_mem_ready;
    logic [31:0] i_mem_addr;
    logic        i_mem_ren;
    logic        i_mem_wen;
    logic [31:0] i_mem_wdata;
    logic [31:0] o_mem_rdata;
    logic        o_mem_valid;
    logic        o_err;

    modport slave (
        output o_mem_ready, o_mem_rdata, o_mem_valid, o_err,
        input  i_mem_addr, i_mem_ren, i_mem_wen, i_mem_wdata
    );

    modport master (
        input  o_mem_ready, o_mem_rdata, o_mem_valid, o_err,
        output i_mem_addr, i_mem_ren, i_mem_wen, i_mem_wdata
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency in-order memory responder.
// Every accepted request waits exactly LATENCY edges in an in-order queue,
// then retires: writes commit to storage, reads register the storage word
// and pulse o_mem_valid for one cycle. Storage has no reset.
module mem_responder #(
    parameter int AW      = 10,
    parameter int LATENCY = 4,
    parameter int QDEPTH  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_responder_if.slave  bus,
    output logic [4:0]      o_dbg_occupancy
);

    localparam int            PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [3:0]    LAT   = 4'(LATENCY);
    localparam logic [4:0]    QMAX  = 5'(QDEPTH);
    localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);

    // One queue slot: age counts edges since acceptance, starting at 1 on
    // the accept edge, so the head retires on the edge after age hits LAT.
    typedef struct packed {
        logic          vld;
        logic          is_wr;
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
        logic [3:0]    age;
    } entry_t;

    entry_t        ent_q [QDEPTH];
    entry_t        ent_d [QDEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [4:0]    occ_q, occ_d;
    logic          err_q, err_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [2**AW];

    logic          ready;
    logic          req_ok;
    logic          req_bad;
    logic          accept;
    logic          retire;
    logic          mem_we;
    logic [AW-1:0] req_idx;
    entry_t        head_ent;
    logic          unused_addr_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PLAST) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on registered occupancy, so a retiring slot is
    // offered to a new request one cycle later, never on the same edge.
    assign ready    = (occ_q < QMAX);
    assign req_idx  = bus.i_mem_addr[AW+1:2];
    assign req_ok   = bus.i_mem_ren ^ bus.i_mem_wen;
    assign req_bad  = bus.i_mem_ren & bus.i_mem_wen;
    assign accept   = ready & req_ok;
    assign head_ent = ent_q[head_q];
    assign retire   = head_ent.vld && (head_ent.age == LAT);
    assign mem_we   = retire && head_ent.is_wr;

    assign unused_addr_bits = ^{bus.i_mem_addr[31:AW+2], bus.i_mem_addr[1:0]};

    // Next-state for queue, pointers, occupancy, response and error flag.
    always_comb begin
        ent_d    = ent_q;
        head_d   = head_q;
        tail_d   = tail_q;
        occ_d    = occ_q;
        err_d    = err_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;

        for (int i = 0; i < QDEPTH; i++) begin
            if (ent_q[i].vld && (ent_q[i].age < LAT)) begin
                ent_d[i].age = ent_q[i].age + 4'd1;
            end
        end

        if (retire) begin
            ent_d[head_q].vld = 1'b0;
            head_d            = ptr_inc(head_q);
            if (!head_ent.is_wr) begin
                rvalid_d = 1'b1;
                rdata_d  = mem[head_ent.idx];
            end
        end

        if (accept) begin
            ent_d[tail_q] = '{vld: 1'b1, is_wr: bus.i_mem_wen, idx: req_idx,
                              wdata: bus.i_mem_wdata, age: 4'd1};
            tail_d        = ptr_inc(tail_q);
        end

        if (ready && req_bad) begin
            err_d = 1'b1;
        end

        occ_d = occ_q + {4'd0, accept} - {4'd0, retire};
    end

    // Control state; reset drops every in-flight request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ent_q    <= ent_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage commits retiring writes; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[head_ent.idx] <= head_ent.wdata;
        end
    end

    assign bus.o_mem_ready = ready;
    assign bus.o_mem_valid = rvalid_q;
    assign bus.o_mem_rdata = rdata_q;
    assign bus.o_err       = err_q;
    assign o_dbg_occupancy = occ_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic against a
// time-stamped reference model with an expected-response queue.
module tb_mem_responder;

    localparam int AW  = 10;
    localparam int LAT = 4;
    localparam int QD  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] dbg_occ;

    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(.AW(AW), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .bus             (bus),
        .o_dbg_occupancy (dbg_occ)
    );

    typedef struct {
        int          e;
        int          idx;
        logic [31:0] d;
    } pend_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          edge_n = 0;
    logic [31:0] ref_mem [1024];
    bit          ref_known [1024];
    pend_t       pend_q [$];
    int          acc_q [$];
    logic [32:0] exp_q [$];
    int          exp_t_q [$];
    int          err_edge = -1;
    logic [31:0] last_exp = '0;
    bit          last_known = 1'b1;
    bit          in_reset = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // Edge counter; writes become visible in the model at their retire edge.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        while (pend_q.size() > 0 && pend_q[0].e + LAT == edge_n) begin
            ref_mem[pend_q[0].idx]   = pend_q[0].d;
            ref_known[pend_q[0].idx] = 1'b1;
            void'(pend_q.pop_front());
        end
    end

    // Monitor: compares outputs every cycle against the expected queue.
    always @(negedge clk) begin : monitor
        bit          due;
        logic [32:0] e;
        if (!in_reset) begin
            due = (exp_t_q.size() > 0) && (exp_t_q[0] == edge_n);
            check("valid", {31'd0, bus.o_mem_valid}, {31'd0, due});
            if (due) begin
                e = exp_q.pop_front();
                void'(exp_t_q.pop_front());
                last_known = e[32];
                last_exp   = e[31:0];
                if (e[32] && bus.o_mem_valid) check("rdata", bus.o_mem_rdata, e[31:0]);
            end else if (last_known) begin
                check("rdata_hold", bus.o_mem_rdata, last_exp);
            end
            check("err", {31'd0, bus.o_err}, {31'd0, (err_edge >= 0 && edge_n >= err_edge)});
        end
    end

    // Drive one cycle of inputs (called at a falling edge) and record in the
    // model what the coming rising edge will do.
    task automatic step(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wd, output bit acc);
        int          n;
        int          idx;
        bit          mready;
        logic [32:0] e;
        n = edge_n + 1;
        while (acc_q.size() > 0 && acc_q[0] < n - LAT) void'(acc_q.pop_front());
        mready = acc_q.size() < QD;
        check("ready", {31'd0, bus.o_mem_ready}, {31'd0, mready});
        check("occupancy", {27'd0, dbg_occ}, 32'(acc_q.size()));
        bus.i_mem_ren   = ren;
        bus.i_mem_wen   = wen;
        bus.i_mem_addr  = addr;
        bus.i_mem_wdata = wd;
        acc = 1'b0;
        if (mready && (ren ^ wen)) begin
            acc = 1'b1;
            acc_q.push_back(n);
            idx = int'(addr[AW+1:2]);
            if (wen) begin
                pend_q.push_back('{e: n, idx: idx, d: wd});
            end else begin
                e = {ref_known[idx], ref_mem[idx]};
                for (int k = 0; k < pend_q.size(); k++) begin
                    if (pend_q[k].idx == idx) e = {1'b1, pend_q[k].d};
                end
                exp_q.push_back(e);
                exp_t_q.push_back(n + LAT);
            end
        end else if (mready && ren && wen && err_edge < 0) begin
            err_edge = n;
        end
        @(negedge clk);
    endtask

    // Hold a legal request until it is taken, within a cycle budget.
    task automatic send(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wd);
        bit acc;
        int tries;
        tries = 0;
        do begin
            step(ren, wen, addr, wd, acc);
            tries++;
        end while (!acc && tries < 50);
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got not-accepted expected accepted at edge %0d", edge_n);
        end
    endtask

    task automatic idle(input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'd0, 32'd0, acc);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {31'd0, bus.o_mem_valid}, 32'd0);
        check("rst_ready", {31'd0, bus.o_mem_ready}, 32'd1);
        check("rst_rdata", bus.o_mem_rdata, 32'd0);
        check("rst_err", {31'd0, bus.o_err}, 32'd0);
        check("rst_occ", {27'd0, dbg_occ}, 32'd0);
    endtask

    // Pulse reset between edges and discard everything the model had in flight.
    task automatic do_reset();
        #2;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        bus.i_mem_ren = 1'b0;
        bus.i_mem_wen = 1'b0;
        pend_q.delete();
        acc_q.delete();
        exp_q.delete();
        exp_t_q.delete();
        err_edge = -1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        last_exp   = '0;
        last_known = 1'b1;
        rst_n      = 1'b1;
        in_reset   = 1'b0;
    endtask

    task automatic random_traffic(input int count);
        bit          acc;
        int          r;
        logic [31:0] a;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            if (r < 4)      step(1'b1, 1'b0, a, 32'd0, acc);
            else if (r < 7) step(1'b0, 1'b1, a, $urandom, acc);
            else            step(1'b0, 1'b0, a, $urandom, acc);
        end
    endtask

    initial begin
        bus.i_mem_ren   = 1'b0;
        bus.i_mem_wen   = 1'b0;
        bus.i_mem_addr  = '0;
        bus.i_mem_wdata = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n    = 1'b1;
        in_reset = 1'b0;

        // Known contents for every index the traffic touches.
        for (int i = 0; i < 16; i++) send(1'b0, 1'b1, 32'(i) << 2, $urandom);
        send(1'b0, 1'b1, 32'h300, 32'h1111_1111);

        // Write then read the same word on consecutive edges.
        send(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        send(1'b1, 1'b0, 32'h100, 32'd0);
        idle(LAT + 2);

        // Preload four words then read them back to back.
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'(i + 1));
        idle(LAT + 1);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'd0);
        idle(LAT + 2);

        // Hold more reads than the queue holds so ready drops and recovers.
        for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 32'h200 + 32'((i % 4) * 4), 32'd0);
        idle(LAT + 2);

        // High address bits alias onto the same word.
        send(1'b0, 1'b1, 32'h1004, 32'h0000_A5A5);
        send(1'b1, 1'b0, 32'h0004, 32'd0);
        idle(LAT + 2);

        random_traffic(300);
        idle(LAT + 2);

        // Simultaneous read and write: refused, sticky error.
        begin
            bit acc;
            step(1'b1, 1'b1, 32'h40, 32'h1234_5678, acc);
        end
        idle(LAT + 3);

        // Reset with a write and reads in flight.
        send(1'b0, 1'b1, 32'h300, 32'h0000_0055);
        send(1'b1, 1'b0, 32'h300, 32'd0);
        send(1'b1, 1'b0, 32'h300, 32'd0);
        do_reset();
        send(1'b1, 1'b0, 32'h300, 32'd0);
        idle(LAT + 2);

        random_traffic(150);
        idle(LAT + 4);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
